// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: one outstanding imem request, output register plus
// one-entry skid buffer, redirect squash, sticky halt. Define FETCH_PERF_CNT_EN for perf counters.
module fetch_ctrl #(
  parameter int           N        = 32,
  parameter logic [N-1:0] RESET_PC = N'(32'h0000_0000)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall_i,
  input  logic         redirect_i,
  input  logic [N-1:0] redirect_pc,
  input  logic         halt_i,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_ack,
  input  logic [N-1:0] imem_rdata,
  output logic         if_valid,
  output logic [N-1:0] if_instr,
  output logic [N-1:0] if_pc,
  output logic [N-1:0] if_pc_inc4,
  output logic         halted,
  output logic [31:0]  fetch_cnt,
  output logic [31:0]  stall_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_HALT} state_e;

  state_e       state_q, state_d;
  logic [N-1:0] addr_q, addr_d;
  logic [N-1:0] redir_pc_q, redir_pc_d;
  logic         squash_q, squash_d;
  logic         halt_q, halt_d;
  logic         out_valid_q, out_valid_d;
  logic [N-1:0] out_instr_q, out_instr_d;
  logic [N-1:0] out_pc_q, out_pc_d;
  logic         skid_valid_q, skid_valid_d;
  logic [N-1:0] skid_instr_q, skid_instr_d;
  logic [N-1:0] skid_pc_q, skid_pc_d;

  logic         consume;
  logic         slot_free;
  logic         halt_pend;
  logic [N-1:0] addr_inc;

  assign consume   = out_valid_q && !stall_i;
  assign slot_free = !out_valid_q || consume;
  assign halt_pend = halt_q || halt_i;
  assign addr_inc  = addr_q + N'(4);

  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves a variable unassigned (no latches).
    state_d      = state_q;
    addr_d       = addr_q;
    redir_pc_d   = redir_pc_q;
    squash_d     = squash_q;
    halt_d       = halt_pend;
    out_valid_d  = out_valid_q && !consume;
    out_instr_d  = out_instr_q;
    out_pc_d     = out_pc_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;

    case (state_q)
      S_IDLE: begin
        state_d = halt_pend ? S_HALT : S_REQ;
      end

      S_REQ: begin
        if (redirect_i) begin
          out_valid_d  = 1'b0;
          skid_valid_d = 1'b0;
          if (imem_ack) begin
            // Data returning this cycle belongs to the old path; relaunch at once.
            addr_d   = redirect_pc;
            squash_d = 1'b0;
            if (halt_pend) state_d = S_HALT;
          end else begin
            // imem_addr must stay put until the in-flight ack arrives.
            redir_pc_d = redirect_pc;
            squash_d   = 1'b1;
          end
        end else if (imem_ack) begin
          if (squash_q) begin
            addr_d   = redir_pc_q;
            squash_d = 1'b0;
            if (halt_pend) state_d = S_HALT;
          end else begin
            addr_d = addr_inc;
            if (slot_free) begin
              out_valid_d = 1'b1;
              out_instr_d = imem_rdata;
              out_pc_d    = addr_q;
              if (halt_pend) state_d = S_HALT;
            end else begin
              skid_valid_d = 1'b1;
              skid_instr_d = imem_rdata;
              skid_pc_d    = addr_q;
              state_d      = S_HOLD;
            end
          end
        end
      end

      S_HOLD: begin
        if (redirect_i) begin
          out_valid_d  = 1'b0;
          skid_valid_d = 1'b0;
          addr_d       = redirect_pc;
          state_d      = halt_pend ? S_HALT : S_REQ;
        end else if (consume) begin
          out_valid_d  = 1'b1;
          out_instr_d  = skid_instr_q;
          out_pc_d     = skid_pc_q;
          skid_valid_d = 1'b0;
          state_d      = halt_pend ? S_HALT : S_REQ;
        end
      end

      S_HALT: begin
        if (consume && skid_valid_q) begin
          out_valid_d  = 1'b1;
          out_instr_d  = skid_instr_q;
          out_pc_d     = skid_pc_q;
          skid_valid_d = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      addr_q       <= RESET_PC;
      redir_pc_q   <= RESET_PC;
      squash_q     <= 1'b0;
      halt_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      // NOTE: payload registers are reset too, so if_instr/if_pc read 0 straight out of reset.
      out_instr_q  <= '0;
      out_pc_q     <= '0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
      state_q      <= state_d;
      addr_q       <= addr_d;
      redir_pc_q   <= redir_pc_d;
      squash_q     <= squash_d;
      halt_q       <= halt_d;
      out_valid_q  <= out_valid_d;
      out_instr_q  <= out_instr_d;
      out_pc_q     <= out_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  assign imem_req   = (state_q == S_REQ);
  assign imem_addr  = addr_q;
  assign if_valid   = out_valid_q;
  assign if_instr   = out_instr_q;
  assign if_pc      = out_pc_q;
  assign if_pc_inc4 = out_pc_q + N'(4);
  assign halted     = (state_q == S_HALT);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q + 32'(consume);
    stall_cnt_d = stall_cnt_q + 32'(out_valid_q && stall_i);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;
`else
  assign fetch_cnt = '0;
  assign stall_cnt = '0;
`endif

endmodule
